// File: rtl/regfile_nport.sv
// Parametrised multi-read-port register file with one write port.
// Reads are either combinational or registered with write-first forwarding.
module regfile_nport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int RD_REG   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_nport: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  // A write to the hardwired zero register is dropped here, so it can never forward either.
  assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic [DATA_W-1:0] stored;

    assign ra      = raddr[i*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign stored  = is_zero ? '0 : mem_q[ra];

    if (RD_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rdata_q;
      logic [DATA_W-1:0] rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (re[i]) begin
          rdata_d = (wr_en && (waddr == ra)) ? wdata : stored;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign rdata[i*DATA_W +: DATA_W] = rdata_q;
    end else begin : g_comb
      assign rdata[i*DATA_W +: DATA_W] = stored;
    end
  end

  if (RD_REG == 0) begin : g_no_re
    logic unused_re;
    assign unused_re = ^re;
  end

endmodule
